// File: rtl/bin2bcd_display.sv
// Iterative double-dabble binary-to-BCD converter feeding the 4-digit display.
// Inputs above 9999 saturate to 9999 and flag ovf.
module bin2bcd_display #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] bin_in,
  input  logic            bin_valid,
  output logic            bin_ready,
  output logic [15:0]     bcd_out,
  output logic            bcd_valid,
  output logic            ovf
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [IN_W-1:0] SAT = IN_W'(9999);

  state_t          state, state_nxt;
  logic [IN_W-1:0] bin_q;
  logic [15:0]     acc_q;
  logic [15:0]     acc_adj;
  logic [15:0]     acc_nxt;
  logic            pend_q;
  logic [4:0]      cnt_q;
  logic            accept;
  logic            last;
  logic            sat;

  assign bin_ready = (state == IDLE);
  assign accept    = bin_valid & bin_ready;
  assign last      = (state == SHIFT) && (cnt_q == 5'd1);
  assign sat       = (bin_in > SAT);

  // All nibbles corrected from pre-shift values, then one left shift.
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      else
        acc_adj[4*i +: 4] = acc_q[4*i +: 4];
    end
    acc_nxt = {acc_adj[14:0], bin_q[IN_W-1]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      acc_q     <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (accept) begin
        bin_q  <= sat ? SAT : bin_in;
        acc_q  <= '0;
        pend_q <= sat;
        cnt_q  <= 5'(IN_W);
      end else if (state == SHIFT) begin
        acc_q <= acc_nxt;
        bin_q <= {bin_q[IN_W-2:0], 1'b0};
        cnt_q <= cnt_q - 5'd1;
        if (last) begin
          bcd_out   <= acc_nxt;
          ovf       <= pend_q;
          bcd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench for bin2bcd_display: driver pushes expected results,
// a negedge monitor pops and checks value, ovf and latency.
module tb_bin2bcd_display;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] bin_in;
  logic            bin_valid;
  logic            bin_ready;
  logic [15:0]     bcd_out;
  logic            bcd_valid;
  logic            ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [16:0] exp_q[$];
  int          due_q[$];
  int          vcyc_q[$];

  bin2bcd_display #(.IN_W(IN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bin_in(bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bcd_out(bcd_out),
    .bcd_valid(bcd_valid),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] ref_model(input int v);
    int m;
    m = (v > 9999) ? 9999 : v;
    return {(v > 9999) ? 1'b1 : 1'b0,
            4'(m / 1000), 4'((m / 100) % 10),
            4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every bcd_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bcd_valid) begin
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_bcd_valid", 1, 0);
      end else begin
        logic [16:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("bcd_out", int'(bcd_out), int'(e[15:0]));
        check("ovf", int'(ovf), int'(e[16]));
        check("latency", cyc, d);
      end
    end
  end

  task automatic send(input int v, input bit hold, input bit expect_out);
    int n;
    n = 0;
    @(negedge clk);
    bin_in    = IN_W'(v);
    bin_valid = 1'b1;
    while (!bin_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bin_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (expect_out) begin
        exp_q.push_back(ref_model(v));
        due_q.push_back(cyc + 1 + IN_W);
      end
      @(posedge clk);
      #1;
      if (!hold) bin_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    int c0;
    rst       = 1'b1;
    bin_valid = 1'b1;
    bin_in    = IN_W'(77);
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    bin_valid = 1'b0;
    check("rst_bcd_out", int'(bcd_out), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_bcd_valid", int'(bcd_valid), 0);
    check("rst_ready", int'(bin_ready), 1);
    @(negedge clk);
    check("post_rst_ready", int'(bin_ready), 1);

    // Convert 0, ready low for exactly 14 cycles
    send(0, 1'b0, 1'b1);
    ok = 1;
    for (int i = 0; i < IN_W; i++) begin
      @(negedge clk);
      if (bin_ready) ok = 0;
    end
    @(negedge clk);
    check("ready_low_14", ok, 1);
    check("ready_back", int'(bin_ready), 1);
    drain();

    // 1234 then 10; output holds during second conversion
    send(1234, 1'b0, 1'b1);
    drain();
    send(10, 1'b0, 1'b1);
    ok = 1;
    for (int i = 0; i < IN_W - 1; i++) begin
      @(negedge clk);
      if (bcd_out != 16'h1234) ok = 0;
    end
    check("hold_1234", ok, 1);
    drain();

    send(9999, 1'b0, 1'b1);
    send(12000, 1'b0, 1'b1);
    send(5, 1'b0, 1'b1);
    drain();

    // Back-to-back with bin_valid held high
    vcyc_q.delete();
    send(42, 1'b1, 1'b1);
    send(7, 1'b0, 1'b1);
    drain();
    if (vcyc_q.size() == 2) check("b2b_gap", vcyc_q[1] - vcyc_q[0], IN_W + 1);
    else check("b2b_pulses", vcyc_q.size(), 2);

    // Reset at the 6th SHIFT cycle
    send(8765, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_bcd_out", int'(bcd_out), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    check("mid_rst_ready", int'(bin_ready), 1);
    c0 = vcyc_q.size();
    repeat (20) @(negedge clk);
    check("no_valid_after_rst", vcyc_q.size() - c0, 0);
    send(321, 1'b0, 1'b1);
    drain();

    // Strided sweep plus boundaries
    for (int v = 0; v < (1 << IN_W); v += 11) send(v, 1'b0, 1'b1);
    send(9998, 1'b0, 1'b1);
    send(10000, 1'b0, 1'b1);
    send(10001, 1'b0, 1'b1);
    send((1 << IN_W) - 1, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
